// File: rtl/dds_pkg.sv
// Shared types and constants for the multi-channel DDS register sequencer:
// FSM state encoding, AD9911-class register addresses and the default
// register image written to every device after master reset.
package dds_pkg;

  // Sequencer states; encoding is fixed so DBG_STATE values stay stable.
  typedef enum logic [3:0] {
    ST_HOLD     = 4'd0,
    ST_STAB     = 4'd1,
    ST_I_LOAD   = 4'd2,
    ST_I_WAIT   = 4'd3,
    ST_I_STROBE = 4'd4,
    ST_READY    = 4'd5,
    ST_U_WAIT   = 4'd6,
    ST_U_STROBE = 4'd7,
    ST_U_DONE   = 4'd8
  } dds_state_t;

  // Device register addresses.
  localparam logic [7:0] ADDR_CSR   = 8'd0;
  localparam logic [7:0] ADDR_FR1   = 8'd1;
  localparam logic [7:0] ADDR_FR2   = 8'd2;
  localparam logic [7:0] ADDR_CFR   = 8'd3;
  localparam logic [7:0] ADDR_CTW0  = 8'd4;
  localparam logic [7:0] ADDR_CPOW0 = 8'd5;
  localparam logic [7:0] ADDR_ACR   = 8'd6;
  localparam logic [7:0] ADDR_LSR   = 8'd7;
  localparam logic [7:0] ADDR_RDW   = 8'd8;
  localparam logic [7:0] ADDR_FDW   = 8'd9;
  localparam logic [7:0] ADDR_CTW1  = 8'd10;

  // Default init image; word i is written to address i.
  localparam int IMAGE_LEN = 11;
  localparam logic [31:0] INIT_IMAGE [0:IMAGE_LEN-1] = '{
    32'h0000_0020,
    32'h00B3_0400,
    32'h0000_0000,
    32'h00C0_0300,
    32'd17895698,
    32'h0000_0000,
    32'h0001_DFFF,
    32'h0000_0000,
    32'h0000_0000,
    32'h0000_0000,
    32'h8000_0000
  };

endpackage

// File: rtl/dds_init_rom.sv
// Combinational init-image lookup: register index -> image word.
// Indices past the default image (when NREG > 11) read as zero.
module dds_init_rom #(
  parameter int NREG = 11,
  parameter int DW   = 32,
  parameter int IW   = 4
) (
  input  logic [IW-1:0] idx,
  output logic [DW-1:0] word
);
  import dds_pkg::*;

  // Select the image word for the requested index.
  always_comb begin
    word = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i < IMAGE_LEN && int'(idx) == i) word = DW'(INIT_IMAGE[i]);
    end
  end

endmodule

// File: rtl/dds_multi_updater.sv
// Multi-channel DDS register sequencer. After INITI rises it releases the
// devices from master reset, waits for them to settle, writes the init
// image to every channel, then serves masked frequency-word updates.
// Optional BUSY watchdog: define DDS_TIMEOUT_EN.
//
// Handshakes: UPDATE is sampled only in READY; the requester holds off
// further requests until the one-cycle UPDATED pulse. Toward the writers a
// TR pulse is issued only after BUSY is low on every targeted channel, and
// ADDR/DATA are held stable from the load cycle through the strobe cycle.
module dds_multi_updater #(
  parameter int NCH        = 2,
  parameter int NREG       = 11,
  parameter int DW         = 32,
  parameter int CTW_ADDR   = 4,
  parameter int INIT_DELAY = 2048,
  parameter logic [NCH*DW-1:0] BASE_FREQW = {32'd0, 32'd370440929},
  parameter int TIMEOUT    = 4096
) (
  input  logic              CLOCK_10M,
  input  logic              RESET_N,
  input  logic              INITI,
  output logic              INITIED,
  input  logic [DW-1:0]     FREQW,
  input  logic [NCH-1:0]    CH_MASK,
  input  logic              UPDATE,
  output logic              UPDATED,
  output logic              ERR,
  output logic [NCH-1:0]    DDS_TR,
  output logic [NCH*8-1:0]  DDS_ADDR,
  output logic [NCH*DW-1:0] DDS_DATA,
  output logic [NCH-1:0]    DDS_MRSET,
  input  logic [NCH-1:0]    DDS_BUSY,
  output logic [3:0]        DBG_STATE
);
  import dds_pkg::*;

  localparam int IW = $clog2(NREG + 1);
  localparam int CW = $clog2(INIT_DELAY + 2);

  dds_state_t        state;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     load_idx;
  logic [CW-1:0]     dcnt;
  logic [NCH-1:0]    mask;
  logic [NCH*8-1:0]  addr_q;
  logic [NCH*DW-1:0] data_q;
  logic [DW-1:0]     rom_word;
  logic              initied_q;
  logic              busy_init;
  logic              busy_upd;
  logic              timeout;

  // The strobe state loads the next word, so look one index ahead there.
  assign load_idx  = (state == ST_I_STROBE) ? idx + IW'(1) : idx;
  assign busy_init = |DDS_BUSY;
  assign busy_upd  = |(DDS_BUSY & mask);

  dds_init_rom #(.NREG(NREG), .DW(DW), .IW(IW)) u_rom (
    .idx  (load_idx),
    .word (rom_word)
  );

`ifdef DDS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;
  logic          waiting;
  logic          wait_busy;
  logic          err_q;

  assign waiting   = (state == ST_I_WAIT) || (state == ST_U_WAIT);
  assign wait_busy = (state == ST_I_WAIT) ? busy_init : busy_upd;
  assign timeout   = waiting && wait_busy && (wcnt == TW'(TIMEOUT - 1));

  // Count consecutive stalled wait cycles; cleared whenever the wait ends.
  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) wcnt <= '0;
    else if (!INITI || !waiting || !wait_busy || timeout) wcnt <= '0;
    else wcnt <= wcnt + TW'(1);
  end

  // Sticky watchdog flag, cleared only by reset or by dropping INITI.
  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) err_q <= 1'b0;
    else if (!INITI) err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign ERR = err_q;
`else
  assign timeout = 1'b0;
  assign ERR     = 1'b0;
`endif

  // Main sequencer: init image load followed by update service.
  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_HOLD;
      idx       <= '0;
      dcnt      <= '0;
      mask      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      initied_q <= 1'b0;
    end else if (!INITI) begin
      state     <= ST_HOLD;
      idx       <= '0;
      dcnt      <= '0;
      mask      <= '0;
      initied_q <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          idx   <= '0;
          dcnt  <= '0;
          state <= ST_STAB;
        end
        ST_STAB: begin
          if (dcnt > CW'(INIT_DELAY)) begin
            state <= ST_I_LOAD;
            for (int k = 0; k < NCH; k++) begin
              addr_q[k*8 +: 8]   <= 8'(load_idx);
              data_q[k*DW +: DW] <= rom_word;
            end
          end else begin
            dcnt <= dcnt + CW'(1);
          end
        end
        ST_I_LOAD: state <= ST_I_WAIT;
        ST_I_WAIT: begin
          if (timeout) state <= ST_HOLD;
          else if (!busy_init) state <= ST_I_STROBE;
        end
        ST_I_STROBE: begin
          if (idx == IW'(NREG - 1)) begin
            state     <= ST_READY;
            initied_q <= 1'b1;
          end else begin
            idx   <= load_idx;
            state <= ST_I_LOAD;
            for (int k = 0; k < NCH; k++) begin
              addr_q[k*8 +: 8]   <= 8'(load_idx);
              data_q[k*DW +: DW] <= rom_word;
            end
          end
        end
        ST_READY: begin
          if (UPDATE) begin
            mask <= CH_MASK;
            for (int k = 0; k < NCH; k++) begin
              if (CH_MASK[k]) begin
                addr_q[k*8 +: 8]   <= 8'(CTW_ADDR);
                data_q[k*DW +: DW] <= BASE_FREQW[k*DW +: DW] + FREQW;
              end
            end
            state <= (CH_MASK == '0) ? ST_U_DONE : ST_U_WAIT;
          end
        end
        ST_U_WAIT: begin
          if (timeout) state <= ST_U_DONE;
          else if (!busy_upd) state <= ST_U_STROBE;
        end
        ST_U_STROBE: state <= ST_U_DONE;
        ST_U_DONE:   state <= ST_READY;
        default:     state <= ST_HOLD;
      endcase
    end
  end

  // Strobes, master reset and done pulse decode directly from the state.
  always_comb begin
    DDS_TR = '0;
    if (state == ST_I_STROBE) DDS_TR = '1;
    else if (state == ST_U_STROBE) DDS_TR = mask;
  end

  assign DDS_MRSET = (state == ST_HOLD) ? '1 : '0;
  assign UPDATED   = (state == ST_U_DONE);
  assign INITIED   = initied_q;
  assign DDS_ADDR  = addr_q;
  assign DDS_DATA  = data_q;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_dds_multi_updater.sv
// Self-checking bench for dds_multi_updater at default parameters.
// Stimulus pushes expected writer events into a queue; a negedge monitor
// pops and compares whenever TR or UPDATED is seen.
`timescale 1ns/1ps
module tb_dds_multi_updater;
  localparam int NCH        = 2;
  localparam int DW         = 32;
  localparam int INIT_DELAY = 2048;
  localparam int NREG       = 11;
  localparam int TIMEOUT    = 4096;
  localparam int EW         = NCH + 1 + NCH*8 + NCH*DW;
  localparam int INIT_LAT   = INIT_DELAY + 2 + 3*NREG + 1; // edges from drive negedge

  logic              CLOCK_10M = 1'b0;
  logic              RESET_N   = 1'b0;
  logic              INITI     = 1'b0;
  logic              UPDATE    = 1'b0;
  logic [DW-1:0]     FREQW     = '0;
  logic [NCH-1:0]    CH_MASK   = '0;
  logic [NCH-1:0]    DDS_BUSY  = '0;
  logic              INITIED;
  logic              UPDATED;
  logic              ERR;
  logic [NCH-1:0]    DDS_TR;
  logic [NCH*8-1:0]  DDS_ADDR;
  logic [NCH*DW-1:0] DDS_DATA;
  logic [NCH-1:0]    DDS_MRSET;
  logic [3:0]        DBG_STATE;

  dds_multi_updater dut (
    .CLOCK_10M (CLOCK_10M),
    .RESET_N   (RESET_N),
    .INITI     (INITI),
    .INITIED   (INITIED),
    .FREQW     (FREQW),
    .CH_MASK   (CH_MASK),
    .UPDATE    (UPDATE),
    .UPDATED   (UPDATED),
    .ERR       (ERR),
    .DDS_TR    (DDS_TR),
    .DDS_ADDR  (DDS_ADDR),
    .DDS_DATA  (DDS_DATA),
    .DDS_MRSET (DDS_MRSET),
    .DDS_BUSY  (DDS_BUSY),
    .DBG_STATE (DBG_STATE)
  );

  // Clock / cycle counter
  always #50 CLOCK_10M = ~CLOCK_10M;
  int cyc = 0;
  always @(posedge CLOCK_10M) cyc <= cyc + 1;

  initial begin
    #6000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] img [0:10] = '{32'h0000_0020, 32'h00B3_0400, 32'h0, 32'h00C0_0300,
                              32'd17895698, 32'h0, 32'h0001_DFFF, 32'h0, 32'h0, 32'h0,
                              32'h8000_0000};
  logic [31:0] base0 = 32'd370440929;
  logic [31:0] base1 = 32'd0;
  logic [7:0]  cur_a0 = '0, cur_a1 = '0;
  logic [31:0] cur_d0 = '0, cur_d1 = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [EW-1:0] pack_ev(input logic [1:0] tr, input logic upd);
    return {tr, upd, cur_a1, cur_a0, cur_d1, cur_d0};
  endfunction

  task automatic push_init(input int i);
    cur_a0 = 8'(i); cur_a1 = 8'(i);
    cur_d0 = img[i]; cur_d1 = img[i];
    exp_q.push_back(pack_ev(2'b11, 1'b0));
  endtask

  // Model the register load done in READY for the masked channels.
  task automatic load_upd(input logic [1:0] mask, input logic [31:0] fw);
    if (mask[0]) begin cur_a0 = 8'd4; cur_d0 = base0 + fw; end
    if (mask[1]) begin cur_a1 = 8'd4; cur_d1 = base1 + fw; end
  endtask

  // Monitor: every TR or UPDATED cycle must match the next expected event
  always @(negedge CLOCK_10M) begin
    if (RESET_N && (DDS_TR != '0 || UPDATED === 1'b1)) begin
      if (exp_q.size() == 0)
        check("unexpected_event", 128'({DDS_TR, UPDATED, DDS_ADDR, DDS_DATA}), 128'(0));
      else
        check("event", 128'({DDS_TR, UPDATED, DDS_ADDR, DDS_DATA}), 128'(exp_q.pop_front()));
    end
  end

  // Wait for INITIED, checking its latency from the INITI drive negedge m.
  task automatic wait_initied(input int m, input string name, input bit stray_update);
    int t;
    t = -1;
    CH_MASK = 2'b11;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLOCK_10M);
      UPDATE = stray_update && (i == 20);
      if (INITIED === 1'b1) begin t = cyc - m; break; end
    end
    UPDATE = 1'b0;
    check(name, 128'(t), 128'(INIT_LAT));
  endtask

  // Issue one update and check TR / UPDATED latency from the READY cycle.
  task automatic do_update(input string name, input logic [31:0] fw, input logic [1:0] mask,
                           input logic [1:0] bmask, input int blen,
                           input int exp_tr, input int exp_upd);
    int n, tr_t, upd_t;
    load_upd(mask, fw);
    if (mask != 2'b00) exp_q.push_back(pack_ev(mask, 1'b0));
    exp_q.push_back(pack_ev(2'b00, 1'b1));
    @(negedge CLOCK_10M);
    n = cyc; FREQW = fw; CH_MASK = mask; UPDATE = 1'b1;
    if (blen > 0) DDS_BUSY = bmask;
    tr_t = -1; upd_t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLOCK_10M);
      UPDATE = 1'b0;
      if (cyc - n >= blen + 1) DDS_BUSY = '0;
      if (DDS_TR != '0 && tr_t < 0) tr_t = cyc - n;
      if (UPDATED === 1'b1) begin upd_t = cyc - n; break; end
    end
    if (mask != 2'b00) check({name, "_tr_lat"}, 128'(tr_t), 128'(exp_tr));
    check({name, "_upd_lat"}, 128'(upd_t), 128'(exp_upd));
    @(negedge CLOCK_10M);
    check({name, "_upd_one_cycle"}, 128'(UPDATED), 128'(0));
  endtask

  // Main stimulus
  initial begin
    int m, cnt;
    repeat (3) @(negedge CLOCK_10M);
    check("rst_mrset",   128'(DDS_MRSET), 128'(2'b11));
    check("rst_initied", 128'(INITIED),   128'(0));
    check("rst_updated", 128'(UPDATED),   128'(0));
    check("rst_err",     128'(ERR),       128'(0));
    check("rst_tr",      128'(DDS_TR),    128'(0));
    check("rst_addr",    128'(DDS_ADDR),  128'(0));
    check("rst_data",    128'(DDS_DATA),  128'(0));

    RESET_N = 1'b1;
    repeat (4) @(negedge CLOCK_10M);
    check("hold_mrset", 128'(DDS_MRSET), 128'(2'b11));
    check("hold_state", 128'(DBG_STATE), 128'(0));

    // Full init, with a stray UPDATE during stabilisation that must be ignored
    for (int i = 0; i < 11; i++) push_init(i);
    m = cyc; INITI = 1'b1;
    @(negedge CLOCK_10M);
    check("stab_mrset", 128'(DDS_MRSET), 128'(2'b00));
    wait_initied(m - 1 + 1, "init_latency", 1'b1);
    @(negedge CLOCK_10M);
    check("init_drained", 128'(exp_q.size()), 128'(0));
    check("ready_state",  128'(DBG_STATE),    128'(5));
    check("ready_err",    128'(ERR),          128'(0));

    // Updates
    do_update("u_ch0",    32'd1000,      2'b01, 2'b00, 0, 2, 3);
    do_update("u_busy",   32'd1000,      2'b11, 2'b10, 5, 7, 8);
    do_update("u_wrap",   32'hFFFF_FFFF, 2'b01, 2'b00, 0, 2, 3);
    check("wrap_data0", 128'(DDS_DATA[31:0]), 128'(32'd370440928));
    do_update("u_nomask", 32'd5,         2'b00, 2'b00, 0, 0, 1);

    // Drop INITI mid-init at index 5, then restart from index 0
    @(negedge CLOCK_10M); INITI = 1'b0;
    @(negedge CLOCK_10M);
    check("drop_mrset",   128'(DDS_MRSET), 128'(2'b11));
    check("drop_initied", 128'(INITIED),   128'(0));
    repeat (3) @(negedge CLOCK_10M);
    for (int i = 0; i < 5; i++) push_init(i);
    for (int i = 0; i < 11; i++) push_init(i);
    INITI = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLOCK_10M);
      if (DDS_TR != '0) cnt++;
      if (cnt == 5) begin INITI = 1'b0; break; end
    end
    check("mid_tr_count", 128'(cnt), 128'(5));
    @(negedge CLOCK_10M);
    check("mid_mrset", 128'(DDS_MRSET), 128'(2'b11));
    check("mid_state", 128'(DBG_STATE), 128'(0));
    check("mid_tr",    128'(DDS_TR),    128'(0));
    repeat (4) @(negedge CLOCK_10M);
    m = cyc; INITI = 1'b1;
    wait_initied(m, "reinit_latency", 1'b0);
    @(negedge CLOCK_10M);
    check("reinit_drained", 128'(exp_q.size()), 128'(0));

`ifdef DDS_TIMEOUT_EN
    begin
      int n, upd_t, tr_seen;
      load_upd(2'b01, 32'd7);
      exp_q.push_back(pack_ev(2'b00, 1'b1));
      @(negedge CLOCK_10M);
      n = cyc; FREQW = 32'd7; CH_MASK = 2'b01; UPDATE = 1'b1; DDS_BUSY = 2'b01;
      upd_t = -1; tr_seen = 0;
      for (int i = 0; i < 5000; i++) begin
        @(negedge CLOCK_10M);
        UPDATE = 1'b0;
        if (DDS_TR != '0) tr_seen = 1;
        if (UPDATED === 1'b1) begin upd_t = cyc - n; break; end
      end
      DDS_BUSY = '0;
      check("to_upd_lat", 128'(upd_t),   128'(TIMEOUT + 1));
      check("to_no_tr",   128'(tr_seen), 128'(0));
      @(negedge CLOCK_10M);
      check("to_err_set", 128'(ERR), 128'(1));
      INITI = 1'b0;
      @(negedge CLOCK_10M);
      check("to_err_clr", 128'(ERR), 128'(0));
    end
`endif

    repeat (3) @(negedge CLOCK_10M);
    check("final_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
